scale_writer: RTL and testbench
===============================

Name: scale_writer

Overview:
- Write-side counterpart of the display scaler: takes a camera pixel stream and downsamples it into the 240x320 frame buffer.
- The display side upscales buffer contents to screen coordinates; this block does the reverse, decimating source coordinates to buffer coordinates.
- Generates the BRAM write enable, address and data, and marks frame completion.
- Sits between the camera pixel reconstructor and the frame-buffer BRAM write port.

Parameters:
BUF_W, 240, frame-buffer width in pixels
BUF_H, 320, frame-buffer height in pixels
DATA_W, 16, pixel width (RGB565)
ADDR_W, 17, buffer address width (ceil(log2(BUF_W*BUF_H)))

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
scale_in  input  2  requested scale: 00=1:1, 10=÷4 horizontal ÷2 vertical, 11=÷2 both, 01=reserved
valid_in  input  1  source pixel valid
hcount_in  input  11  source pixel column
vcount_in  input  10  source pixel row
pixel_in  input  DATA_W  source pixel data
we_out  output  1  buffer write enable
addr_out  output  ADDR_W  buffer write address
data_out  output  DATA_W  buffer write data
busy_out  output  1  high while a frame is being captured
frame_done_out  output  1  one-cycle pulse on the final write of a frame
abort_out  output  1  one-cycle pulse when a new frame start arrives while busy

Behaviour:
- Reset (async, rst_n_in=0): we_out=0, addr_out=0, data_out=0, busy_out=0, frame_done_out=0, abort_out=0, FSM=IDLE, latched scale=00, pipeline valids cleared.
- Frame start (fs) = valid_in & hcount_in==0 & vcount_in==0.
- FSM:
  - IDLE -> ACTIVE on fs with scale_in != 01. scale_in is latched at fs and held for the whole frame; scale_in changes mid-frame are ignored.
  - fs with scale 01 stays in IDLE and produces no writes.
  - ACTIVE -> IDLE on the cycle the last-address write enters stage 2.
  - fs while ACTIVE: pulse abort_out, relatch scale, restart the frame (stay in ACTIVE). The in-flight stage-1 pixel of the old frame is discarded.
- busy_out = (FSM==ACTIVE), registered.
- Stage 1 (keep/decimate), computed on valid_in in ACTIVE or on fs:
  - 00: keep all pixels; sh=h, sv=v. Window h<240, v<320.
  - 10: keep h[1:0]==0 and v[0]==0; sh=h>>2, sv=v>>1. Window h<960, v<640.
  - 11: keep h[0]==0 and v[0]==0; sh=h>>1, sv=v>>1. Window h<480, v<480.
  - Pixels outside the window are dropped silently.
- Address: addr = sv*240 + sh, computed as (sv<<8)-(sv<<4)+sh, zero-extended to ADDR_W. Register sv, sh and pixel in stage 1; register addr, data and we in stage 2.
- Latency: exactly 2 clk from an accepted valid_in to we_out. Back-to-back valid accepted every cycle. No backpressure.
- Last address, by latched scale:
  - 00 and 10: 76799 (sv=319, sh=239).
  - 11: 57599 (sv=239, sh=239).
- frame_done_out is asserted in the same cycle as we_out for the last address. After that, further pixels are ignored until the next fs.
- Writes are not required to arrive in order. Any kept pixel writes its own address; duplicate coordinates simply overwrite.
- Reset mid-frame: outputs clear immediately and the pipeline is flushed. No write may complete after rst_n_in falls.

Decomposition:
- Shared package (frame_buf_pkg):
  - BUF_W, BUF_H, ADDR_W constants
  - scale_t enum: SCALE_1X=2'b00, SCALE_RSVD=2'b01, SCALE_4X2=2'b10, SCALE_2X=2'b11
  - writer state_t: IDLE, ACTIVE
  - per-scale window limits and last-address constants
- One sub-module, scale_decimate: combinational keep/window check plus sh/sv shift for a given scale_t. Its window decode must match the display scaler so both sides agree on the buffer map.

Test Plan:
- Scale 00, raster 240x320 then a further pixel at (0,0): 76800 writes. Addr at (h=5, v=2) = 485. frame_done with addr 76799. we 2 cycles after each valid.
- Scale 10, full 960x640 raster: 76800 writes. Pixel (h=8, v=4) -> addr 482. Pixel (h=9, v=4) and pixel (h=8, v=5) -> no write. Pixels with h>=960 -> dropped.
- Scale 11, 480x480 raster: 57600 writes. frame_done at addr 57599. Pixel (h=100, v=50) -> addr 6050.
- Mid-frame switch of scale_in from 00 to 11 at v=10: addresses continue per scale 00. The next fs latches 11.
- fs at (0,0) while ACTIVE at v=100: abort_out one pulse. The next write goes to addr 0. busy_out stays 1.
- Assert rst_n_in mid-frame with valid pixels in the pipeline: we_out=0 within the same cycle, busy_out=0. The first write after release requires a new fs. Also, scale 01 -> zero writes.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Frame-buffer geometry, scale encoding and writer state shared by the
// capture-side writer and the display-side scaler.
package frame_buf_pkg;

   localparam int BUF_W  = 240;
   localparam int BUF_H  = 320;
   localparam int ADDR_W = 17;
   localparam int SH_W   = 8;   // buffer column width (0..239)
   localparam int SV_W   = 9;   // buffer row width (0..319)

   typedef enum logic [1:0] {
      SCALE_1X   = 2'b00,
      SCALE_RSVD = 2'b01,
      SCALE_4X2  = 2'b10,
      SCALE_2X   = 2'b11
   } scale_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Exclusive upper bounds on source coordinates for each scale.
   localparam int H_LIM_1X  = BUF_W;
   localparam int V_LIM_1X  = BUF_H;
   localparam int H_LIM_4X2 = 4 * BUF_W;
   localparam int V_LIM_4X2 = 2 * BUF_H;
   localparam int H_LIM_2X  = 2 * BUF_W;
   localparam int V_LIM_2X  = 2 * BUF_W;

   // The 2x mode fills a square BUF_W x BUF_W region only.
   localparam int LAST_ADDR_FULL = BUF_W * BUF_H - 1;
   localparam int LAST_ADDR_2X   = BUF_W * BUF_W - 1;

   function automatic logic [ADDR_W-1:0] last_addr(input scale_t scale);
      return (scale == SCALE_2X) ? ADDR_W'(LAST_ADDR_2X) : ADDR_W'(LAST_ADDR_FULL);
   endfunction

endpackage

// File: rtl/scale_decimate.sv
// Keep/window decode and source-to-buffer coordinate shift for one scale.
// Must stay in step with the display scaler so both agree on the buffer map.
module scale_decimate
   import frame_buf_pkg::*;
(
   input  scale_t            scale,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   output logic              keep,
   output logic [SH_W-1:0]   sh,
   output logic [SV_W-1:0]   sv
);

   always_comb begin
      // NOTE: every output gets a default first so no case path can infer a latch.
      keep = 1'b0;
      sh   = '0;
      sv   = '0;
      case (scale)
         SCALE_1X: begin
            keep = (hcount < 11'(H_LIM_1X)) && (vcount < 10'(V_LIM_1X));
            sh   = hcount[7:0];
            sv   = vcount[8:0];
         end
         SCALE_4X2: begin
            keep = (hcount[1:0] == 2'b00) && !vcount[0] &&
                   (hcount < 11'(H_LIM_4X2)) && (vcount < 10'(V_LIM_4X2));
            sh   = hcount[9:2];
            sv   = vcount[9:1];
         end
         SCALE_2X: begin
            keep = !hcount[0] && !vcount[0] &&
                   (hcount < 11'(H_LIM_2X)) && (vcount < 10'(V_LIM_2X));
            sh   = hcount[8:1];
            sv   = vcount[9:1];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/scale_writer.sv
// Decimates a camera pixel stream into the 240x320 frame buffer: two-stage
// pipeline producing BRAM write enable/address/data plus frame status pulses.
module scale_writer
   import frame_buf_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [1:0]        scale_in,
   input  logic              valid_in,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic [DATA_W-1:0] pixel_in,
   output logic              we_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] data_out,
   output logic              busy_out,
   output logic              frame_done_out,
   output logic              abort_out
);

   state_t              state;
   scale_t              scale_req, scale_q, scale_sel;
   logic                fs, restart, kill_s1, accept, keep;
   logic [SH_W-1:0]     sh, s1_sh;
   logic [SV_W-1:0]     sv, s1_sv;
   logic [DATA_W-1:0]   s1_pix;
   logic [ADDR_W-1:0]   s1_addr;
   logic                s1_valid, s1_last;

   assign scale_req = scale_t'(scale_in);
   assign fs        = valid_in && (hcount_in == '0) && (vcount_in == '0);
   assign restart   = fs && (scale_req != SCALE_RSVD);
   assign kill_s1   = fs && (state == ACTIVE);

   // A frame start decodes with the incoming scale; all other pixels use the latched one.
   assign scale_sel = fs ? scale_req : scale_q;

   scale_decimate u_decimate (
      .scale  (scale_sel),
      .hcount (hcount_in),
      .vcount (vcount_in),
      .keep   (keep),
      .sh     (sh),
      .sv     (sv)
   );

   // sv*240 + sh without a multiplier.
   assign s1_addr = (ADDR_W'(s1_sv) << 8) - (ADDR_W'(s1_sv) << 4) + ADDR_W'(s1_sh);
   assign s1_last = s1_valid && (s1_addr == last_addr(scale_q));

   // Once the final address sits in stage 1, nothing but a new frame start is taken.
   assign accept = valid_in && keep &&
                   (restart || ((state == ACTIVE) && !fs && !s1_last));

   // NOTE: non-blocking assignments so every register here samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         scale_q        <= SCALE_1X;
         busy_out       <= 1'b0;
         abort_out      <= 1'b0;
         s1_valid       <= 1'b0;
         s1_sh          <= '0;
         s1_sv          <= '0;
         s1_pix         <= '0;
         we_out         <= 1'b0;
         addr_out       <= '0;
         data_out       <= '0;
         frame_done_out <= 1'b0;
      end else begin
         abort_out <= kill_s1;

         case (state)
            IDLE: begin
               if (restart) begin
                  state    <= ACTIVE;
                  busy_out <= 1'b1;
                  scale_q  <= scale_req;
               end
            end
            ACTIVE: begin
               if (fs) begin
                  if (restart) begin
                     scale_q <= scale_req;
                  end else begin
                     state    <= IDLE;
                     busy_out <= 1'b0;
                  end
               end else if (s1_last) begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end
            end
         endcase

         s1_valid <= accept;
         if (accept) begin
            s1_sh  <= sh;
            s1_sv  <= sv;
            s1_pix <= pixel_in;
         end

         // A restart drops the old frame's stage-1 pixel instead of writing it.
         we_out         <= s1_valid && !kill_s1;
         frame_done_out <= s1_last && !kill_s1;
         if (s1_valid && !kill_s1) begin
            addr_out <= s1_addr;
            data_out <= s1_pix;
         end
      end
   end

endmodule

// File: tb/tb_scale_writer.sv
// Randomised self-checking bench for scale_writer; expected writes come from a
// coordinate-level model of the decimation rules and frame sequencing.
`timescale 1ns/1ps
module tb_scale_writer;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 17;

   logic              clk    = 1'b0;
   logic              rst_n  = 1'b0;
   logic [1:0]        scale  = 2'b00;
   logic              valid  = 1'b0;
   logic [10:0]       hcount = '0;
   logic [9:0]        vcount = '0;
   logic [DATA_W-1:0] pixel  = '0;
   logic              we_o, busy_o, done_o, abort_o;
   logic [ADDR_W-1:0] addr_o;
   logic [DATA_W-1:0] data_o;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   scale_writer #(.DATA_W(DATA_W)) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .scale_in       (scale),
      .valid_in       (valid),
      .hcount_in      (hcount),
      .vcount_in      (vcount),
      .pixel_in       (pixel),
      .we_out         (we_o),
      .addr_out       (addr_o),
      .data_out       (data_o),
      .busy_out       (busy_o),
      .frame_done_out (done_o),
      .abort_out      (abort_o)
   );

   // Decimation rules: divide by (dh,dv), keep exact multiples inside the buffer.
   function automatic void ref_map(input int sc, input int h, input int v,
                                   output bit keep, output int addr, output int last);
      int dh = 1, dv = 1, rows = 320;
      keep = 1'b0;
      addr = 0;
      last = -1;
      case (sc)
         0:       begin dh = 1; dv = 1; rows = 320; end
         2:       begin dh = 4; dv = 2; rows = 320; end
         3:       begin dh = 2; dv = 2; rows = 240; end
         default: return;
      endcase
      last = rows * 240 - 1;
      if ((h % dh == 0) && (v % dv == 0) && (h / dh < 240) && (v / dv < rows)) begin
         keep = 1'b1;
         addr = (v / dv) * 240 + h / dh;
      end
   endfunction

   // Reference model: frame sequencing per clock, writes appear two edges after acceptance.
   bit              m_active, m_last_pend, p_valid, p_last;
   int              m_scale, p_addr;
   logic [15:0]     p_data;
   bit              e_we, e_done, e_abort, e_busy, e_chk_ad;
   int              e_addr;
   logic [15:0]     e_data;

   always @(posedge clk) begin : model
      bit fs, take, keep;
      int addr, last;
      if (!rst_n) begin
         m_active = 0; m_last_pend = 0; p_valid = 0; p_last = 0; m_scale = 0;
         p_addr = 0; p_data = '0;
         e_we = 0; e_done = 0; e_abort = 0; e_busy = 0; e_addr = 0; e_data = '0;
         e_chk_ad = 1;
      end else begin
         fs       = valid && (hcount == 0) && (vcount == 0);
         e_we     = p_valid && !(fs && m_active);
         e_addr   = p_addr;
         e_data   = p_data;
         e_done   = e_we && p_last;
         e_abort  = fs && m_active;
         e_chk_ad = e_we;
         p_valid  = 0;
         p_last   = 0;
         take     = 0;
         if (fs) begin
            m_last_pend = 0;
            if (scale != 2'b01) begin
               m_active = 1; m_scale = int'(scale); take = 1;
            end else begin
               m_active = 0;
            end
         end else if (m_active && m_last_pend) begin
            m_active = 0; m_last_pend = 0;
         end else begin
            take = m_active && valid;
         end
         if (take) begin
            ref_map(m_scale, int'(hcount), int'(vcount), keep, addr, last);
            if (keep) begin
               p_valid = 1; p_addr = addr; p_data = pixel;
               p_last = (addr == last);
               m_last_pend = p_last;
            end
         end
         e_busy = m_active;
      end
      #1;
      vectors++;
      if (we_o !== e_we) begin
         miscompares++; $display("FAIL we @%0t: got %b want %b", $time, we_o, e_we);
      end
      vectors++;
      if (done_o !== e_done) begin
         miscompares++; $display("FAIL frame_done @%0t: got %b want %b", $time, done_o, e_done);
      end
      vectors++;
      if (abort_o !== e_abort) begin
         miscompares++; $display("FAIL abort @%0t: got %b want %b", $time, abort_o, e_abort);
      end
      vectors++;
      if (busy_o !== e_busy) begin
         miscompares++; $display("FAIL busy @%0t: got %b want %b", $time, busy_o, e_busy);
      end
      if (e_chk_ad) begin
         vectors++;
         if (addr_o !== 17'(e_addr) || data_o !== e_data) begin
            miscompares++;
            $display("FAIL addr_data @%0t: got %0d/%h want %0d/%h", $time, addr_o, data_o, e_addr, e_data);
         end
      end
   end

   task automatic drive(input int h, input int v, input logic [15:0] pix);
      @(negedge clk);
      valid = 1'b1; hcount = 11'(h); vcount = 10'(v); pixel = pix;
   endtask

   task automatic frame_start(input logic [1:0] sc);
      @(negedge clk);
      scale = sc; valid = 1'b1; hcount = '0; vcount = '0; pixel = 16'hF00D;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid = 1'b0;
      end
   endtask

   // Random pixels, avoiding frame starts and the final address so the frame stays open.
   task automatic rand_pixels(input int n, input int sc, input int hmax, input int vmax);
      for (int i = 0; i < n; i++) begin
         int h, v, a, l;
         bit k;
         do begin
            h = $urandom_range(hmax, 0);
            v = $urandom_range(vmax, 0);
            ref_map(sc, h, v, k, a, l);
         end while ((h == 0 && v == 0) || (k && a == l));
         if ($urandom_range(3, 0) == 0) idle(1);
         drive(h, v, 16'($urandom));
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++;
      if ({we_o, done_o, abort_o, busy_o} !== 4'b0 || addr_o !== '0 || data_o !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got we=%b done=%b abort=%b busy=%b addr=%0d data=%h want all zero",
                  we_o, done_o, abort_o, busy_o, addr_o, data_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_scale_1x;
      frame_start(2'b00);
      drive(5, 2, 16'hA5A5);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b1 || addr_o !== 17'd485 || data_o !== 16'hA5A5) begin
         miscompares++; $display("FAIL addr_1x_5_2: got we=%b addr=%0d data=%h want 1/485/a5a5", we_o, addr_o, data_o);
      end
      rand_pixels(1500, 0, 299, 399);
      drive(239, 319, 16'h1234);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (done_o !== 1'b1 || we_o !== 1'b1 || addr_o !== 17'd76799) begin
         miscompares++; $display("FAIL done_1x: got done=%b we=%b addr=%0d want 1/1/76799", done_o, we_o, addr_o);
      end
      drive(10, 10, 16'h5555);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b0 || busy_o !== 1'b0) begin
         miscompares++; $display("FAIL after_done_1x: got we=%b busy=%b want 0/0", we_o, busy_o);
      end
      idle(2);
   endtask

   task automatic test_scale_4x2;
      frame_start(2'b10);
      drive(8, 4, 16'hBEEF);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b1 || addr_o !== 17'd482 || data_o !== 16'hBEEF) begin
         miscompares++; $display("FAIL addr_4x2_8_4: got we=%b addr=%0d data=%h want 1/482/beef", we_o, addr_o, data_o);
      end
      drive(9, 4, 16'h0001);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b0) begin
         miscompares++; $display("FAIL drop_4x2_9_4: got we=%b want 0", we_o);
      end
      drive(8, 5, 16'h0002);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b0) begin
         miscompares++; $display("FAIL drop_4x2_8_5: got we=%b want 0", we_o);
      end
      drive(960, 2, 16'h0003);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b0) begin
         miscompares++; $display("FAIL drop_4x2_h960: got we=%b want 0", we_o);
      end
      rand_pixels(1500, 2, 1100, 700);
      drive(956, 638, 16'h4321);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (done_o !== 1'b1 || addr_o !== 17'd76799) begin
         miscompares++; $display("FAIL done_4x2: got done=%b addr=%0d want 1/76799", done_o, addr_o);
      end
      idle(2);
   endtask

   task automatic test_scale_2x;
      frame_start(2'b11);
      drive(100, 50, 16'hCAFE);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b1 || addr_o !== 17'd6050) begin
         miscompares++; $display("FAIL addr_2x_100_50: got we=%b addr=%0d want 1/6050", we_o, addr_o);
      end
      rand_pixels(1500, 3, 550, 540);
      drive(478, 478, 16'h7777);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (done_o !== 1'b1 || addr_o !== 17'd57599 || busy_o !== 1'b0) begin
         miscompares++; $display("FAIL done_2x: got done=%b addr=%0d busy=%b want 1/57599/0", done_o, addr_o, busy_o);
      end
      idle(2);
   endtask

   task automatic test_scale_switch;
      frame_start(2'b00);
      rand_pixels(200, 0, 239, 9);
      scale = 2'b11;
      drive(6, 10, 16'h6666);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b1 || addr_o !== 17'd2406) begin
         miscompares++; $display("FAIL switch_held: got we=%b addr=%0d want 1/2406", we_o, addr_o);
      end
      frame_start(2'b11);
      drive(100, 50, 16'h9999);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b1 || addr_o !== 17'd6050) begin
         miscompares++; $display("FAIL switch_relatch: got we=%b addr=%0d want 1/6050", we_o, addr_o);
      end
      drive(478, 478, 16'h8888);
      idle(3);
   endtask

   task automatic test_abort;
      frame_start(2'b00);
      rand_pixels(100, 0, 239, 99);
      drive(7, 100, 16'hDEAD);
      frame_start(2'b00);
      @(posedge clk); #1;
      vectors++;
      if (abort_o !== 1'b1 || we_o !== 1'b0 || busy_o !== 1'b1) begin
         miscompares++; $display("FAIL abort_pulse: got abort=%b we=%b busy=%b want 1/0/1", abort_o, we_o, busy_o);
      end
      idle(1); @(posedge clk); #1;
      vectors++;
      if (abort_o !== 1'b0 || we_o !== 1'b1 || addr_o !== '0 || data_o !== 16'hF00D || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_restart: got abort=%b we=%b addr=%0d data=%h busy=%b want 0/1/0/f00d/1",
                  abort_o, we_o, addr_o, data_o, busy_o);
      end
      idle(2);
   endtask

   task automatic test_reset_mid;
      frame_start(2'b00);
      for (int i = 1; i < 20; i++) drive(i, 3, 16'(i));
      @(posedge clk); #2;
      vectors++;
      if (we_o !== 1'b1) begin
         miscompares++; $display("FAIL pre_reset_we: got %b want 1", we_o);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (we_o !== 1'b0 || busy_o !== 1'b0 || addr_o !== '0) begin
         miscompares++; $display("FAIL reset_mid: got we=%b busy=%b addr=%0d want 0/0/0", we_o, busy_o, addr_o);
      end
      idle(3);
      rst_n = 1'b1;
      drive(5, 5, 16'h1111);
      drive(6, 5, 16'h2222);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b0 || busy_o !== 1'b0) begin
         miscompares++; $display("FAIL no_fs_after_reset: got we=%b busy=%b want 0/0", we_o, busy_o);
      end
      frame_start(2'b01);
      drive(2, 0, 16'h3333);
      drive(4, 2, 16'h4444);
      idle(1); @(posedge clk); #1;
      vectors++;
      if (we_o !== 1'b0 || busy_o !== 1'b0) begin
         miscompares++; $display("FAIL reserved_scale: got we=%b busy=%b want 0/0", we_o, busy_o);
      end
      idle(3);
   endtask

   initial begin
      test_reset;
      test_scale_1x;
      test_scale_4x2;
      test_scale_2x;
      test_scale_switch;
      test_abort;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
